// File: rtl/adc_sar_ctrl_if.sv
// ---------------------------------------------------------------------------
// adc_sar_ctrl_if
// Bundles the control, comparator and result signals of the SAR ADC
// controller. The slave modport is the controller's view. The master modport
// is the view of whatever issues conversion requests and models the
// comparator.
//
// Signals:
//   start     request a conversion (ignored while busy)
//   abort     cancel the conversion in progress
//   comp      comparator result, 1 = Vin >= Vdac(dac_code)
//   sample    sample/hold switch enable to the analog macro
//   dac_code  trial code presented to the capacitor DAC
//   busy      conversion in progress (sampling or converting)
//   done      one-cycle pulse, result updated this cycle
//   result    last completed conversion
// ---------------------------------------------------------------------------
interface adc_sar_ctrl_if #(
  parameter int NBITS = 10
) ();

  logic             start;
  logic             abort;
  logic             comp;
  logic             sample;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;

  modport master (
    output start,
    output abort,
    output comp,
    input  sample,
    input  dac_code,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  abort,
    input  comp,
    output sample,
    output dac_code,
    output busy,
    output done,
    output result
  );

endinterface

// File: rtl/adc_sar_ctrl.sv
// ---------------------------------------------------------------------------
// adc_sar_ctrl
// Successive-approximation controller for the ADC macro. It drives the
// sample/hold switch and the capacitor-DAC trial code. It resolves one result
// bit per trial from the comparator, MSB first, and publishes the final code
// with a one-cycle done pulse.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   adc_sar_ctrl_if.slave: start/abort/comp in,
//         sample/dac_code/busy/done/result out (all outputs registered)
// ---------------------------------------------------------------------------
module adc_sar_ctrl #(
  parameter int NBITS      = 10,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 2
) (
  input logic           clk,
  input logic           rst,
  adc_sar_ctrl_if.slave bus
);

  // A parameter value of 1 would give a zero-width counter, so keep at least one bit
  localparam int SCW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam int TCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int BW  = $clog2(NBITS);

  localparam logic [NBITS-1:0] ONE         = NBITS'(1);
  localparam logic [SCW-1:0]   SAMP_LAST   = SCW'(SAMPLE_CYC - 1);
  localparam logic [TCW-1:0]   SETTLE_LAST = TCW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0]    MSB_IDX     = BW'(NBITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMP,
    ST_CONV,
    ST_DONE
  } state_t;

  state_t           state, state_n;
  logic [SCW-1:0]   samp_cnt, samp_cnt_n;
  logic [TCW-1:0]   settle_cnt, settle_cnt_n;
  logic [BW-1:0]    bit_idx, bit_idx_n;
  logic             sample_q, sample_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [NBITS-1:0] dac_q, dac_n;
  logic [NBITS-1:0] result_q, result_n;
  logic [NBITS-1:0] decided;

  // Next-state and next-output logic. Every output is computed for the state
  // being entered and then registered, so the outputs change together with the
  // state. During conversion the DAC code register also serves as the working
  // register. It holds the decided upper bits plus the current trial bit.
  always_comb begin
    state_n      = state;
    samp_cnt_n   = samp_cnt;
    settle_cnt_n = settle_cnt;
    bit_idx_n    = bit_idx;
    sample_n     = 1'b0;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    dac_n        = '0;
    result_n     = result_q;
    decided      = dac_q;

    case (state)
      // Idle and done accept a new request the same way. This allows
      // back-to-back conversions. Abort always blocks a start.
      ST_IDLE, ST_DONE: begin
        if (bus.start && !bus.abort) begin
          state_n    = ST_SAMP;
          samp_cnt_n = '0;
          sample_n   = 1'b1;
          busy_n     = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end

      // Hold the sample switch closed for the acquisition window. Then present
      // the MSB trial code.
      ST_SAMP: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
        end else if (samp_cnt == SAMP_LAST) begin
          state_n      = ST_CONV;
          bit_idx_n    = MSB_IDX;
          settle_cnt_n = '0;
          busy_n       = 1'b1;
          dac_n        = ONE << MSB_IDX;
        end else begin
          samp_cnt_n = samp_cnt + SCW'(1);
          sample_n   = 1'b1;
          busy_n     = 1'b1;
        end
      end

      // Each trial holds its code for the settle window. On the last cycle the
      // comparator keeps or clears the trial bit. Then the next lower bit is
      // tried, or the result is published once bit 0 is decided.
      ST_CONV: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
        end else if (settle_cnt != SETTLE_LAST) begin
          settle_cnt_n = settle_cnt + TCW'(1);
          busy_n       = 1'b1;
          dac_n        = dac_q;
        end else begin
          decided = bus.comp ? dac_q : (dac_q & ~(ONE << bit_idx));
          if (bit_idx == '0) begin
            state_n  = ST_DONE;
            done_n   = 1'b1;
            result_n = decided;
          end else begin
            bit_idx_n    = bit_idx - BW'(1);
            settle_cnt_n = '0;
            busy_n       = 1'b1;
            dac_n        = decided | (ONE << (bit_idx - BW'(1)));
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers. Reset is synchronous and overrides
  // every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      samp_cnt   <= '0;
      settle_cnt <= '0;
      bit_idx    <= '0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dac_q      <= '0;
      result_q   <= '0;
    end else begin
      state      <= state_n;
      samp_cnt   <= samp_cnt_n;
      settle_cnt <= settle_cnt_n;
      bit_idx    <= bit_idx_n;
      sample_q   <= sample_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      dac_q      <= dac_n;
      result_q   <= result_n;
    end
  end

  assign bus.sample   = sample_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dac_code = dac_q;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_sar_ctrl
// Drives two controller instances: the default 10-bit configuration and a
// fast 12-bit configuration. An ideal comparator (vin >= dac_code) stands in
// for the analog macro. Expected trial codes come straight from the input
// voltage: the bits of vin above the trial bit, followed by a 1 at the trial bit.
// ---------------------------------------------------------------------------
module tb_adc_sar_ctrl;

  localparam int N  = 10;
  localparam int SC = 4;
  localparam int ST = 2;
  localparam int NB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  vin_a;
  logic [NB-1:0] vin_b;
  logic [N-1:0]  last_result;
  logic [N-1:0]  rv;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            t0, d1, d2, k, pulses;

  adc_sar_ctrl_if #(.NBITS(N))  a ();
  adc_sar_ctrl_if #(.NBITS(NB)) b ();

  // Ideal comparators standing in for the analog macro
  assign a.comp = (vin_a >= a.dac_code);
  assign b.comp = (vin_b >= b.dac_code);

  adc_sar_ctrl #(.NBITS(N), .SAMPLE_CYC(SC), .SETTLE_CYC(ST)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  adc_sar_ctrl #(.NBITS(NB), .SAMPLE_CYC(1), .SETTLE_CYC(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  // Free-running clock and a cycle counter for latency measurements
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected DAC code while bit i of input v is on trial
  function automatic logic [31:0] trialOf(input int v, input int i);
    return 32'(((v >> (i + 1)) << (i + 1)) | (1 << i));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the request inputs of the 10-bit instance on a falling edge
  task automatic applyStimulus(input logic s, input logic ab);
    @(negedge clk);
    a.start = s;
    a.abort = ab;
  endtask

  // Follow one full conversion cycle by cycle. The task is entered on the
  // falling edge before the edge that accepts start. It returns on the
  // falling edge inside the DONE cycle and gives that cycle number in done_at.
  task automatic convA(input logic [N-1:0] v, input bit keep_start, output int done_at);
    vin_a = v;
    for (int c = 0; c < SC; c++) begin
      @(negedge clk);
      if (!keep_start) a.start = 1'b0;
      checkOutput("samp_sample", 32'(a.sample), 1);
      checkOutput("samp_busy", 32'(a.busy), 1);
      checkOutput("samp_dac", 32'(a.dac_code), 0);
      checkOutput("samp_done", 32'(a.done), 0);
    end
    for (int i = N - 1; i >= 0; i--) begin
      for (int s = 0; s < ST; s++) begin
        @(negedge clk);
        checkOutput("conv_dac", 32'(a.dac_code), trialOf(int'(v), i));
        checkOutput("conv_sample", 32'(a.sample), 0);
        checkOutput("conv_busy", 32'(a.busy), 1);
        checkOutput("conv_done", 32'(a.done), 0);
      end
    end
    @(negedge clk);
    done_at = cyc;
    checkOutput("done_pulse", 32'(a.done), 1);
    checkOutput("done_busy", 32'(a.busy), 0);
    checkOutput("done_sample", 32'(a.sample), 0);
    checkOutput("done_dac", 32'(a.dac_code), 0);
    checkOutput("done_result", 32'(a.result), 32'(v));
    last_result = v;
  endtask

  initial begin
    rst     = 1'b1;
    a.start = 1'b0;
    a.abort = 1'b0;
    b.start = 1'b0;
    b.abort = 1'b0;
    vin_a   = '0;
    vin_b   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_sample", 32'(a.sample), 0);
    checkOutput("rst_busy", 32'(a.busy), 0);
    checkOutput("rst_done", 32'(a.done), 0);
    checkOutput("rst_dac", 32'(a.dac_code), 0);
    checkOutput("rst_result", 32'(a.result), 0);

    // Reference conversion with a 25-cycle start-to-done latency
    applyStimulus(1'b1, 1'b0);
    t0 = cyc;
    convA(10'h2AB, 1'b0, d1);
    checkOutput("latency_25", 32'(d1 - t0), 25);
    @(negedge clk);
    checkOutput("post_done_low", 32'(a.done), 0);
    checkOutput("post_idle_busy", 32'(a.busy), 0);
    checkOutput("result_hold", 32'(a.result), 32'(last_result));

    // Abort on the first cycle of bit 5
    applyStimulus(1'b1, 1'b0);
    vin_a = 10'h155;
    for (int c = 0; c < SC; c++) begin
      @(negedge clk);
      a.start = 1'b0;
    end
    repeat (4 * ST) @(negedge clk);
    @(negedge clk);
    checkOutput("abort_pre_dac", 32'(a.dac_code), trialOf(32'h155, 5));
    a.abort = 1'b1;
    @(negedge clk);
    a.abort = 1'b0;
    checkOutput("abort_busy", 32'(a.busy), 0);
    checkOutput("abort_dac", 32'(a.dac_code), 0);
    checkOutput("abort_sample", 32'(a.sample), 0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a.done) pulses++;
    end
    checkOutput("abort_no_done", 32'(pulses), 0);
    checkOutput("abort_result", 32'(a.result), 32'h2AB);

    // Extreme inputs: every trial rejected, every trial kept
    applyStimulus(1'b1, 1'b0);
    convA(10'h000, 1'b0, d1);
    applyStimulus(1'b1, 1'b0);
    convA(10'h3FF, 1'b0, d1);

    // start held high: a single SAMP entry, then back-to-back acceptance in DONE
    applyStimulus(1'b1, 1'b0);
    convA(10'h0F3, 1'b1, d1);
    convA(10'h31C, 1'b0, d2);
    checkOutput("b2b_spacing", 32'(d2 - d1), 25);
    @(negedge clk);
    checkOutput("b2b_idle", 32'(a.busy), 0);

    // Randomized input voltages
    for (int r = 0; r < 4; r++) begin
      rv = N'($urandom_range(0, (1 << N) - 1));
      applyStimulus(1'b1, 1'b0);
      convA(rv, 1'b0, d1);
    end

    // Reset in the middle of a conversion
    applyStimulus(1'b1, 1'b0);
    vin_a = 10'h1C7;
    for (int c = 0; c < SC + 3; c++) begin
      @(negedge clk);
      a.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstconv_busy", 32'(a.busy), 0);
    checkOutput("rstconv_dac", 32'(a.dac_code), 0);
    checkOutput("rstconv_sample", 32'(a.sample), 0);
    checkOutput("rstconv_result", 32'(a.result), 0);

    // Reset during sampling
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    a.start = 1'b0;
    checkOutput("rstsamp_pre", 32'(a.sample), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstsamp_sample", 32'(a.sample), 0);
    checkOutput("rstsamp_busy", 32'(a.busy), 0);
    checkOutput("rstsamp_done", 32'(a.done), 0);
    applyStimulus(1'b1, 1'b0);
    convA(10'h2D4, 1'b0, d1);

    // Fast 12-bit instance: expect done 14 cycles after start
    vin_b = 12'hA5C;
    @(negedge clk);
    b.start = 1'b1;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      b.start = 1'b0;
      if (b.done) begin
        k = c;
        break;
      end
    end
    checkOutput("fast_latency", 32'(k), 14);
    checkOutput("fast_result", 32'(b.result), 32'hA5C);

    // abort and start together while idle: no conversion starts
    @(negedge clk);
    b.start = 1'b1;
    b.abort = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    b.abort = 1'b0;
    checkOutput("abort_start_busy", 32'(b.busy), 0);
    checkOutput("abort_start_sample", 32'(b.sample), 0);
    @(negedge clk);
    checkOutput("abort_start_idle", 32'(b.busy), 0);
    checkOutput("abort_start_result", 32'(b.result), 32'hA5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
